// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared widths and FSM encodings for the two-master Wishbone arbiter
package wb_arb_pkg;

    localparam int ADR_W = 19;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;

    // Encodings double as the one-hot grant vector, so gnt_o is the state register itself.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/wb_arb_timer.sv
// rtl/wb_arb_timer.sv - stalled-strobe counter with one-cycle expiry pulse for the arbiter watchdog
module wb_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (stall) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Expiry is decoded from the register, so it lasts exactly the cycle before the clear.
    assign expire = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/wb_master_arb.sv
// rtl/wb_master_arb.sv - two-master (CPU/DMA) Wishbone arbiter onto one slave bus
// Optional stall watchdog compiled in with WB_ARB_TIMEOUT_EN.
module wb_master_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_tga_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic             m1_tga_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic             s_tga_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o,
    output logic             err_o
);

    arb_state_t state_q, state_d;
    logic       last_q;
    logic       expire;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == OWN0) begin
                last_q <= 1'b0;
            end else if (state_d == OWN1) begin
                last_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o = state_q;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_tga_o = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        if (state_q == OWN0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i & m0_stb_i;
            s_we_o  = m0_we_i;
            s_tga_o = m0_tga_i;
            s_adr_o = m0_adr_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
        end else if (state_q == OWN1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i & m1_stb_i;
            s_we_o  = m1_we_i;
            s_tga_o = m1_tga_i;
            s_adr_o = m1_adr_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic tmr_clear;

    // Restart the stall count on any ack, any ownership change and whenever the bus is idle.
    assign tmr_clear = s_ack_i | expire | (state_d != state_q) | (state_q == IDLE);

    wb_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .stall (s_stb_o & ~s_ack_i),
        .clear (tmr_clear),
        .expire(expire)
    );
`else
    // Watchdog compiled out: no forced terminations ever occur.
    assign expire = (TIMEOUT == 0) & 1'b0;
`endif

    assign err_o    = expire;
    assign m0_ack_o = (s_ack_i | expire) & gnt_o[0] & m0_stb_i;
    assign m1_ack_o = (s_ack_i | expire) & gnt_o[1] & m1_stb_i;
    assign m0_dat_o = (expire & gnt_o[0]) ? {DAT_W{1'b1}} : s_dat_i;
    assign m1_dat_o = (expire & gnt_o[1]) ? {DAT_W{1'b1}} : s_dat_i;

endmodule

// File: tb/tb_wb_master_arb.sv
// tb/tb_wb_master_arb.sv - directed bench for wb_master_arb (watchdog steps under WB_ARB_TIMEOUT_EN)
module tb_wb_master_arb;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i;
    logic [18:0] m0_adr_i;
    logic [1:0]  m0_sel_i;
    logic [15:0] m0_dat_i, m0_dat_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i;
    logic [18:0] m1_adr_i;
    logic [1:0]  m1_sel_i;
    logic [15:0] m1_dat_i, m1_dat_o;
    logic        m1_ack_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_tga_o;
    logic [18:0] s_adr_o;
    logic [1:0]  s_sel_o;
    logic [15:0] s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    wb_master_arb #(.TIMEOUT(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_tga_i(m0_tga_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_tga_i(m1_tga_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_tga_o(s_tga_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge wb_clk_i);
    endtask

    initial begin
        wb_rst_i = 1'b0;
        {m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i} = '0;
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i} = '0;
        m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
        m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0;

        // reset state
        nclk(); nclk();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        wb_rst_i = 1'b1;

        // m0 alone reads 0x00400
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00400; m0_sel_i = 2'b11;
        #1 chk("m0_pre_grant_cyc", 32'(s_cyc_o), 32'h0);
        nclk();
        chk("m0_gnt", 32'(gnt_o), 32'h1);
        chk("m0_adr", 32'(s_adr_o), 32'h00400);
        chk("m0_stb", 32'(s_stb_o), 32'h1);
        chk("m0_stall_ack", 32'(m0_ack_o), 32'h0);
        s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
        #1 chk("m0_ack", 32'(m0_ack_o), 32'h1);
        chk("m0_dat", 32'(m0_dat_o), 32'hBEEF);
        chk("m1_ack_idle", 32'(m1_ack_o), 32'h0);
        chk("m1_dat_bcast", 32'(m1_dat_o), 32'hBEEF);
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1 chk("m0_release_comb", 32'(s_cyc_o), 32'h0);
        nclk();
        chk("idle_after_m0", 32'(gnt_o), 32'h0);

        // reset again so last-owner is back to 1, then simultaneous request
        wb_rst_i = 1'b0; #1 wb_rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00010;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 19'h7FFFF; m1_we_i = 1'b1;
        m1_dat_i = 16'h1234; m1_tga_i = 1'b1; m1_sel_i = 2'b10;
        nclk();
        chk("tie_cpu_first", 32'(gnt_o), 32'h1);
        chk("tie_adr0", 32'(s_adr_o), 32'h00010);
        m0_cyc_i = 1'b0;
        nclk();
        chk("handoff_gnt", 32'(gnt_o), 32'h2);
        chk("handoff_adr", 32'(s_adr_o), 32'h7FFFF);
        chk("handoff_we", 32'(s_we_o), 32'h1);
        chk("handoff_dat", 32'(s_dat_o), 32'h1234);
        chk("handoff_tga", 32'(s_tga_o), 32'h1);
        chk("handoff_sel", 32'(s_sel_o), 32'h2);

        // m1 holds cyc across 3 strobes while m0 requests
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m1_adr_i = 19'(i);
            #1 chk("hold_m1_ack", 32'(m1_ack_o), 32'h1);
            chk("hold_m0_noack", 32'(m0_ack_o), 32'h0);
            chk("hold_adr", 32'(s_adr_o), 32'(i));
            nclk();
            chk("hold_gnt", 32'(gnt_o), 32'h2);
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nclk();
        chk("hold_release_gnt", 32'(gnt_o), 32'h1);

        // alternating grants under continuous competing requests
        m1_cyc_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("alt_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            m0_cyc_i = (i % 2 == 1);
            m1_cyc_i = (i % 2 == 0);
            nclk();
        end
        chk("alt_end_gnt", 32'(gnt_o), 32'h1);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        nclk();
        chk("alt_idle", 32'(gnt_o), 32'h0);
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        nclk();
        chk("tie_after_m0", 32'(gnt_o), 32'h2);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nclk();
        chk("idle_before_stall", 32'(gnt_o), 32'h0);

        // slave never acks m0
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_dat_i = 16'h0042;
        nclk();
        chk("stall_gnt", 32'(gnt_o), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("wd_wait_ack", 32'(m0_ack_o), 32'h0);
            chk("wd_wait_err", 32'(err_o), 32'h0);
            nclk();
        end
        chk("wd_ack", 32'(m0_ack_o), 32'h1);
        chk("wd_dat", 32'(m0_dat_o), 32'hFFFF);
        chk("wd_err", 32'(err_o), 32'h1);
        chk("wd_m1_dat", 32'(m1_dat_o), 32'h0042);
        nclk();
        chk("wd_err_pulse", 32'(err_o), 32'h0);
        chk("wd_ack_pulse", 32'(m0_ack_o), 32'h0);
`else
        for (int i = 0; i < 8; i++) nclk();
        chk("nowd_ack", 32'(m0_ack_o), 32'h0);
        chk("nowd_err", 32'(err_o), 32'h0);
        chk("nowd_gnt", 32'(gnt_o), 32'h1);
`endif
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        nclk();

        // asynchronous reset mid-transfer while m1 owns the bus
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        nclk();
        chk("pre_rst_gnt", 32'(gnt_o), 32'h2);
        chk("pre_rst_stb", 32'(s_stb_o), 32'h1);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0; s_ack_i = 1'b1;
        #1 chk("async_rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("async_rst_gnt", 32'(gnt_o), 32'h0);
        chk("async_rst_ack", 32'(m1_ack_o), 32'h0);
        chk("async_rst_err", 32'(err_o), 32'h0);
        s_ack_i = 1'b0;
        nclk();
        wb_rst_i = 1'b1;
        nclk();
        chk("post_rst_gnt", 32'(gnt_o), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
